// File: rtl/fir_l3_serializer.sv
// -----------------------------------------------------------------------------
// fir_l3_serializer
//
// Output-side companion to the L=3 parallel FIR core. Each block of three
// output samples y(3k), y(3k+1), y(3k+2) is buffered in a small FIFO and
// re-emitted one sample per cycle on a valid/ready stream, oldest first.
//
// Ports:
//   clk        sole clock, rising-edge
//   reset_n    asynchronous active-low reset (flushes pointers, count, lane)
//   blk_valid  a three-sample block is presented
//   blk_ready  block side may transfer (FIFO not full, registered state only)
//   blk_y0     oldest sample of the block, y(3k)
//   blk_y1     middle sample, y(3k+1)
//   blk_y2     newest sample, y(3k+2)
//   out_valid  out_data holds a valid sample (FIFO not empty)
//   out_ready  downstream accepts the sample this cycle
//   out_data   serial sample, bit-exact copy of the selected lane, 0 when empty
//   fill       blocks held, counting a partially drained head block
// -----------------------------------------------------------------------------
module fir_l3_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       blk_valid,
    output logic                       blk_ready,
    input  logic [DATA_WIDTH-1:0]      blk_y0,
    input  logic [DATA_WIDTH-1:0]      blk_y1,
    input  logic [DATA_WIDTH-1:0]      blk_y2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Each entry packs a whole block as {y2, y1, y0}.
    logic [3*DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    lane;

    logic push;
    logic pop;
    logic pop_last;
    logic [3*DATA_WIDTH-1:0] head;

    // Handshake qualifiers. blk_ready looks only at the registered count, so a
    // full FIFO refuses a push even while its head is finishing lane 2.
    assign blk_ready = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = blk_valid && blk_ready;
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && (lane == 2'd2);
    assign fill      = count;

    // Storage needs no reset: out_data is gated by out_valid, so stale
    // entries can never reach the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {blk_y2, blk_y1, blk_y0};
        end
    end

    // Pointer, occupancy and lane bookkeeping. A lane-2 pop frees the head
    // entry; a simultaneous push and lane-2 pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lane   <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                if (lane == 2'd2) begin
                    lane   <= 2'd0;
                    rd_ptr <= rd_ptr + AW'(1);
                end else begin
                    lane <= lane + 2'd1;
                end
            end
            if (push && !pop_last) begin
                count <= count + CW'(1);
            end else if (pop_last && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Output lane select from registered storage and pointers only.
    assign head = mem[rd_ptr];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (lane)
                2'd1:    out_data = head[2*DATA_WIDTH-1:DATA_WIDTH];
                2'd2:    out_data = head[3*DATA_WIDTH-1:2*DATA_WIDTH];
                default: out_data = head[DATA_WIDTH-1:0];
            endcase
        end
    end

endmodule

// File: tb/tb_fir_l3_serializer.sv
// -----------------------------------------------------------------------------
// tb_fir_l3_serializer
//
// Directed bench for fir_l3_serializer. Accepted blocks are pushed sample by
// sample into a reference queue; every accepted output sample is popped and
// compared. Occupancy, handshakes and empty-output gating are derived from the
// queue each cycle.
// -----------------------------------------------------------------------------
module tb_fir_l3_serializer;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic           clk;
    logic           reset_n;
    logic           blk_valid;
    logic           blk_ready;
    logic [DW-1:0]  blk_y0;
    logic [DW-1:0]  blk_y1;
    logic [DW-1:0]  blk_y2;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [2:0]     fill;

    logic [DW-1:0]  sb[$];
    int             checks;
    int             failures;

    fir_l3_serializer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_y0    (blk_y0),
        .blk_y1    (blk_y1),
        .blk_y2    (blk_y2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the reference queue, record any
    // transfer on either side, then advance to the next falling edge.
    task automatic cycle();
        int blocks;
        logic [DW-1:0] exp;
        blocks = (sb.size() + 2) / 3;
        checkOutput("out_valid", out_valid, (sb.size() != 0));
        checkOutput("fill", fill, blocks);
        checkOutput("blk_ready", blk_ready, (blocks != DEPTH));
        if (!out_valid) checkOutput("out_data_empty", out_data, '0);
        if (out_valid && out_ready && sb.size() != 0) begin
            exp = sb.pop_front();
            checkOutput("out_data", out_data, exp);
        end
        if (blk_valid && blk_ready) begin
            sb.push_back(blk_y0);
            sb.push_back(blk_y1);
            sb.push_back(blk_y2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic bv, input logic [DW-1:0] y0,
                                 input logic [DW-1:0] y1, input logic [DW-1:0] y2,
                                 input logic ordy);
        blk_valid = bv;
        blk_y0    = y0;
        blk_y1    = y1;
        blk_y2    = y2;
        out_ready = ordy;
        cycle();
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        blk_valid = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && guard < 200) begin
            cycle();
            guard++;
        end
        checkOutput({tag, "_drained"}, sb.size(), 0);
        checkOutput({tag, "_fill0"}, fill, 0);
    endtask

    initial begin
        logic [DW-1:0] held;
        int i;
        int guard;
        logic acc;

        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        blk_valid = 1'b0;
        blk_y0    = '0;
        blk_y1    = '0;
        blk_y2    = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_blk_ready", blk_ready, 1);
        checkOutput("rst_fill", fill, 0);
        checkOutput("rst_out_data", out_data, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single block, accepted on the first edge after release
        applyStimulus(1'b1, 1, -2, 3, 1'b1);
        checkOutput("single_first", out_data, 1);
        drain("single");

        // Fill to full; fifth block must be refused
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 10*k, 10*k+1, 10*k+2, 1'b0);
        end
        checkOutput("full_blk_ready", blk_ready, 0);
        checkOutput("full_fill", fill, 4);
        applyStimulus(1'b1, 40, 41, 42, 1'b0);
        checkOutput("full_still_4", fill, 4);
        drain("full");

        // Backpressure mid-block
        applyStimulus(1'b1, 200, 201, 202, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        held = out_data;
        checkOutput("bp_lane1", held, 201);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("bp_hold1", out_data, held);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("bp_hold2", out_data, held);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("bp_next", out_data, 202);
        drain("bp");

        // Simultaneous push and lane-2 pop at fill=2
        applyStimulus(1'b1, 100, 101, 102, 1'b0);
        applyStimulus(1'b1, 110, 111, 112, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("simul_pre_fill", fill, 2);
        applyStimulus(1'b1, 120, 121, 122, 1'b1);
        checkOutput("simul_fill", fill, 2);
        checkOutput("simul_head", out_data, 110);
        drain("simul");

        // Wrap-around stream with random backpressure
        i = 0;
        guard = 0;
        while (i < 20 && guard < 2000) begin
            acc = blk_ready;
            applyStimulus(1'b1,
                          -32768 + 1000*i,
                          64'sh7FFF_FFFF_0000_0000 + 64'(i),
                          -(i*12345 + 1),
                          1'($urandom_range(0, 1)));
            if (acc) i++;
            guard++;
        end
        checkOutput("wrap_pushed", i, 20);
        drain("wrap");

        // Mid-operation reset after lane 1 with fill=3
        applyStimulus(1'b1, 300, 301, 302, 1'b0);
        applyStimulus(1'b1, 310, 311, 312, 1'b0);
        applyStimulus(1'b1, 320, 321, 322, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("mid_fill3", fill, 3);
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_fill", fill, 0);
        checkOutput("mid_rst_ready", blk_ready, 1);
        checkOutput("mid_rst_data", out_data, '0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 7, 8, 9, 1'b1);
        checkOutput("post_rst_first", out_data, 7);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
